// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter onto the MAC TX byte stream; 1-cycle grant latency, zero-latency pass-through once granted.
// Backpressure: m_axis_tready is routed to the granted source only; a mid-frame source stall is aborted with an errored tlast.
module eth_tx_frame_arbiter #(
    parameter int N_SRC         = 3,
    parameter int STALL_TIMEOUT = 64,
    localparam int GW           = $clog2(N_SRC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*N_SRC-1:0]   s_axis_tdata,
    input  logic [N_SRC-1:0]     s_axis_tvalid,
    output logic [N_SRC-1:0]     s_axis_tready,
    input  logic [N_SRC-1:0]     s_axis_tlast,
    input  logic [N_SRC-1:0]     s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic [15:0]          abort_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_ABORT = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic [15:0]     abort_cnt_q, abort_cnt_d;

    logic [GW-1:0]   winner;
    logic [GW-1:0]   idx_g;
    logic            any_req;

    logic            sel_vld;
    logic            sel_last;
    logic            sel_user;
    logic [7:0]      sel_dat;

    // Round-robin scan starting just after the most recent owner.
    always_comb begin
        winner  = '0;
        idx_g   = '0;
        any_req = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx_g = GW'((int'(last_grant_q) + k) % N_SRC);
            if (!any_req && s_axis_tvalid[idx_g]) begin
                any_req = 1'b1;
                winner  = idx_g;
            end
        end
    end

    assign sel_vld  = s_axis_tvalid[grant_q];
    assign sel_last = s_axis_tlast[grant_q];
    assign sel_user = s_axis_tuser[grant_q];
    assign sel_dat  = s_axis_tdata[{grant_q, 3'b000} +: 8];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        stall_cnt_d   = stall_cnt_q;
        abort_cnt_d   = abort_cnt_q;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;

        case (state_q)
            S_IDLE: begin
                stall_cnt_d = '0;
                if (any_req) begin
                    grant_d = winner;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                m_axis_tdata           = sel_dat;
                m_axis_tvalid          = sel_vld;
                m_axis_tlast           = sel_last;
                m_axis_tuser           = sel_user;
                s_axis_tready[grant_q] = m_axis_tready;
                if (sel_vld) begin
                    // A valid beat never counts as a stall, even while the MAC holds off.
                    stall_cnt_d = '0;
                    if (m_axis_tready && sel_last) begin
                        last_grant_d = grant_q;
                        state_d      = S_IDLE;
                    end
                end else begin
                    if (stall_cnt_q != 32'hFFFF_FFFF) begin
                        stall_cnt_d = stall_cnt_q + 32'd1;
                    end
                    if (STALL_TIMEOUT > 0 && stall_cnt_q == 32'(STALL_TIMEOUT - 1)) begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_ABORT: begin
                stall_cnt_d   = '0;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
                if (m_axis_tready) begin
                    if (abort_cnt_q != 16'hFFFF) begin
                        abort_cnt_d = abort_cnt_q + 16'd1;
                    end
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Drain the remainder of the aborted source frame without forwarding it.
                s_axis_tready[grant_q] = 1'b1;
                if (sel_vld && sel_last) begin
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_SRC - 1);
            stall_cnt_q  <= '0;
            abort_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            stall_cnt_q  <= stall_cnt_d;
            abort_cnt_q  <= abort_cnt_d;
        end
    end

    assign grant_id    = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign abort_count = abort_cnt_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter: directed frames plus randomized traffic against a frame-level model.
module tb_eth_tx_frame_arbiter;
    localparam int N  = 3;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [8*N-1:0] s_tdata = '0;
    logic [N-1:0]   s_tvalid = '0;
    logic [N-1:0]   s_tready;
    logic [N-1:0]   s_tlast = '0;
    logic [N-1:0]   s_tuser = '0;
    logic [7:0]     m_tdata;
    logic           m_tvalid;
    logic           m_tready = 1'b0;
    logic           m_tlast;
    logic           m_tuser;
    logic [1:0]     grant_id;
    logic           busy;
    logic [15:0]    abort_count;

    always #4 clk = ~clk;

    eth_tx_frame_arbiter #(.N_SRC(N), .STALL_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .grant_id(grant_id), .busy(busy), .abort_count(abort_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Source beat entry: {gap after this beat, tuser, tlast, tdata}
    logic [17:0] srcq [N][$];
    int          hold [N];
    int          rdy_mode = 0;

    // Frame-level model: who owns the MAC, and whether that frame is being aborted or dumped.
    int m_owner, m_last, m_gid, m_quiet, m_aborts;
    bit m_err, m_dump;

    typedef struct { int cyc; int gid; logic [7:0] dat; logic last; logic user; } beat_t;
    beat_t cap[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_gid = 0; m_quiet = 0; m_aborts = 0;
        m_err = 1'b0; m_dump = 1'b0;
    endtask

    task automatic push_beat(input int p, input logic [7:0] d, input bit last, input bit user, input int gap);
        srcq[p].push_back({8'(gap), user, last, d});
    endtask

    task automatic step();
        logic [N-1:0] exp_rdy;
        logic         exp_vld, exp_last, exp_user;
        logic [7:0]   exp_dat;
        logic [N-1:0] hs;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && hold[i] == 0) begin
                s_tvalid[i]        = 1'b1;
                s_tdata[8*i +: 8]  = srcq[i][0][7:0];
                s_tlast[i]         = srcq[i][0][8];
                s_tuser[i]         = srcq[i][0][9];
            end else begin
                s_tvalid[i]        = 1'b0;
                s_tdata[8*i +: 8]  = 8'($urandom);
                s_tlast[i]         = 1'($urandom);
                s_tuser[i]         = 1'($urandom);
            end
        end
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc % 2 == 0);
            default: m_tready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        exp_rdy = '0; exp_vld = 1'b0; exp_dat = 8'h00; exp_last = 1'b0; exp_user = 1'b0;
        if (m_owner >= 0) begin
            if (m_err) begin
                exp_vld = 1'b1; exp_last = 1'b1; exp_user = 1'b1;
            end else if (m_dump) begin
                exp_rdy[m_owner] = 1'b1;
            end else begin
                exp_vld          = s_tvalid[m_owner];
                exp_dat          = s_tdata[8*m_owner +: 8];
                exp_last         = s_tlast[m_owner];
                exp_user         = s_tuser[m_owner];
                exp_rdy[m_owner] = m_tready;
            end
        end
        chk("m_tvalid", 32'(m_tvalid), 32'(exp_vld));
        if (exp_vld) begin
            chk("m_tdata", 32'(m_tdata), 32'(exp_dat));
            chk("m_tlast", 32'(m_tlast), 32'(exp_last));
            chk("m_tuser", 32'(m_tuser), 32'(exp_user));
        end
        chk("s_tready", 32'(s_tready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("abort_count", 32'(abort_count), 32'(m_aborts));
        if (m_tvalid && m_tready) cap.push_back('{cyc, int'(grant_id), m_tdata, m_tlast, m_tuser});

        for (int i = 0; i < N; i++) begin
            hs[i] = s_tvalid[i] && exp_rdy[i];
            if (hs[i]) begin
                hold[i] = int'(srcq[i][0][17:10]);
                void'(srcq[i].pop_front());
            end else if (!s_tvalid[i] && hold[i] > 0) begin
                hold[i]--;
            end
        end

        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (s_tvalid[idx]) begin
                    m_owner = idx; m_gid = idx; m_quiet = 0;
                    break;
                end
            end
        end else if (m_err) begin
            if (m_tready) begin
                m_err = 1'b0; m_dump = 1'b1;
                if (m_aborts < 65535) m_aborts++;
            end
        end else if (m_dump) begin
            if (s_tvalid[m_owner] && s_tlast[m_owner]) begin
                m_last = m_owner; m_owner = -1; m_dump = 1'b0;
            end
        end else if (s_tvalid[m_owner]) begin
            m_quiet = 0;
            if (m_tready && s_tlast[m_owner]) begin
                m_last = m_owner; m_owner = -1;
            end
        end else begin
            m_quiet++;
            if (TO > 0 && m_quiet == TO) m_err = 1'b1;
        end
        cyc++;
    endtask

    function automatic bit pending();
        bit p;
        p = (m_owner >= 0);
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic run(input string nm, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL timeout_%s: still busy after %0d cycles, required idle", nm, n);
        end
        repeat (2) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_tvalid = '1;
        s_tdata  = 24'h5A5A5A;
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tuser", 32'(m_tuser), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_abort_count", 32'(abort_count), 32'd0);
        s_tvalid = '0;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            hold[i] = 0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int exp_order [6];
        int start;
        for (int i = 0; i < N; i++) hold[i] = 0;
        model_reset();
        exp_order = '{0, 1, 2, 0, 1, 2};

        // Single source, 5 bytes on port 1
        do_reset();
        cap.delete();
        rdy_mode = 0;
        for (int k = 0; k < 5; k++) push_beat(1, 8'(8'h11 + k), k == 4, 1'b0, 0);
        start = cyc;
        run("single", 100);
        chk("single_beats", 32'(cap.size()), 32'd5);
        for (int k = 0; k < 5 && k < cap.size(); k++) begin
            chk("single_dat", 32'(cap[k].dat), 32'(8'h11 + k));
            chk("single_cyc", 32'(cap[k].cyc), 32'(start + 1 + k));
            chk("single_last", 32'(cap[k].last), 32'(k == 4));
            chk("single_gid", 32'(cap[k].gid), 32'd1);
        end
        chk("single_aborts", 32'(abort_count), 32'd0);

        // Round robin, all three ports with two 4-byte frames each
        do_reset();
        cap.delete();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < N; i++)
                for (int k = 0; k < 4; k++) push_beat(i, 8'(i*64 + j*16 + k), k == 3, 1'b0, 0);
        run("rr", 200);
        chk("rr_beats", 32'(cap.size()), 32'd24);
        if (cap.size() == 24) begin
            for (int f = 0; f < 6; f++) begin
                for (int k = 0; k < 4; k++) begin
                    int b;
                    b = f*4 + k;
                    chk("rr_gid", 32'(cap[b].gid), 32'(exp_order[f]));
                    chk("rr_dat", 32'(cap[b].dat), 32'(exp_order[f]*64 + (f/3)*16 + k));
                    chk("rr_last", 32'(cap[b].last), 32'(k == 3));
                    if (k > 0) chk("rr_contig", 32'(cap[b].cyc), 32'(cap[b-1].cyc + 1));
                    else if (f > 0) chk("rr_gap", 32'(cap[b].cyc), 32'(cap[b-1].cyc + 2));
                end
            end
        end

        // Backpressure: ready toggles, 64-byte frame
        cap.delete();
        rdy_mode = 1;
        for (int k = 0; k < 64; k++) push_beat(0, 8'(k), k == 63, 1'b0, 0);
        run("bp", 400);
        chk("bp_beats", 32'(cap.size()), 32'd64);
        for (int k = 0; k < 64 && k < cap.size(); k++) begin
            chk("bp_dat", 32'(cap[k].dat), 32'(k));
            chk("bp_last", 32'(cap[k].last), 32'(k == 63));
        end
        chk("bp_aborts", 32'(abort_count), 32'd0);

        // Watchdog: port 2 stalls 8 cycles after its third byte
        cap.delete();
        rdy_mode = 0;
        for (int k = 0; k < 6; k++) push_beat(2, 8'(8'hA0 + k), k == 5, 1'b0, (k == 2) ? 8 : 0);
        run("wd", 100);
        chk("wd_beats", 32'(cap.size()), 32'd4);
        if (cap.size() == 4) begin
            chk("wd_dat2", 32'(cap[2].dat), 32'hA2);
            chk("wd_abort_dat", 32'(cap[3].dat), 32'h00);
            chk("wd_abort_last", 32'(cap[3].last), 32'd1);
            chk("wd_abort_user", 32'(cap[3].user), 32'd1);
            chk("wd_abort_cyc", 32'(cap[3].cyc), 32'(cap[2].cyc + 9));
        end
        chk("wd_aborts", 32'(abort_count), 32'd1);
        chk("wd_drained", 32'(srcq[2].size()), 32'd0);

        // Boundary: source returns in the 8th stall cycle
        cap.delete();
        for (int k = 0; k < 6; k++) push_beat(2, 8'(8'hB0 + k), k == 5, 1'b0, (k == 2) ? 7 : 0);
        run("bnd", 100);
        chk("bnd_beats", 32'(cap.size()), 32'd6);
        if (cap.size() == 6) begin
            chk("bnd_resume_cyc", 32'(cap[3].cyc), 32'(cap[2].cyc + 8));
            chk("bnd_dat", 32'(cap[3].dat), 32'hB3);
            chk("bnd_last", 32'(cap[5].last), 32'd1);
            chk("bnd_user", 32'(cap[5].user), 32'd0);
        end
        chk("bnd_aborts", 32'(abort_count), 32'd1);

        // Async reset mid-frame on port 0, then port 0 wins over 1 and 2
        cap.delete();
        for (int k = 0; k < 10; k++) push_beat(0, 8'(8'hC0 + k), k == 9, 1'b0, 0);
        for (int n = 0; n < 20 && cap.size() < 3; n++) step();
        chk("mid_granted", 32'(grant_id), 32'd0);
        do_reset();
        cap.delete();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 2; k++) push_beat(i, 8'(8'hD0 + i*16 + k), k == 1, 1'b0, 0);
        run("post_rst", 100);
        chk("post_rst_beats", 32'(cap.size()), 32'd6);
        if (cap.size() == 6) begin
            chk("post_rst_first", 32'(cap[0].gid), 32'd0);
            chk("post_rst_second", 32'(cap[2].gid), 32'd1);
            chk("post_rst_third", 32'(cap[4].gid), 32'd2);
        end

        // Randomized traffic with random stalls and backpressure
        rdy_mode = 2;
        for (int f = 0; f < 300; f++) begin
            int p, len;
            p   = $urandom_range(0, N-1);
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                int r, gap;
                r = $urandom_range(0, 99);
                if (r < 70)      gap = 0;
                else if (r < 90) gap = $urandom_range(1, 3);
                else if (r < 95) gap = 7;
                else             gap = $urandom_range(8, 10);
                push_beat(p, 8'($urandom), k == len - 1, ($urandom_range(0, 9) == 0), gap);
            end
        end
        run("random", 40000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_tx_frame_arbiter.md
Name: eth_tx_frame_arbiter

Overview:
- Frame-granular round-robin arbiter that shares the 1G MAC TX AXI-Stream (8-bit) input between N frame sources, e.g. a CPU injector, a loopback path and a test-pattern generator.
- Holds a grant from first beat to tlast, so frames never interleave.
- A stall watchdog terminates a frame whose source stops mid-frame: it sends an errored tlast to the MAC, then flushes the rest of that source frame.
- Sits between the TX sources and the MAC wrapper tx_axis port, in the clk_125mhz domain.

Parameters:
- N_SRC, 3, number of source ports (2..8).
- STALL_TIMEOUT, 64, number of consecutive cycles the granted source may hold tvalid low mid-frame before abort; 0 disables the watchdog.
- GW, $clog2(N_SRC), width of grant_id (derived, not overridable).

Ports:
- clk  input  1  system clock, 125 MHz.
- rst_n  input  1  asynchronous active-low reset.
- s_axis_tdata  input  8*N_SRC  source data; port i occupies bits [8i+7:8i].
- s_axis_tvalid  input  N_SRC  per-source valid.
- s_axis_tready  output  N_SRC  per-source ready.
- s_axis_tlast  input  N_SRC  per-source end of frame.
- s_axis_tuser  input  N_SRC  per-source frame error; forwarded unchanged.
- m_axis_tdata  output  8  data to MAC.
- m_axis_tvalid  output  1  valid to MAC.
- m_axis_tready  input  1  ready from MAC.
- m_axis_tlast  output  1  last to MAC.
- m_axis_tuser  output  1  error to MAC (the MAC drops or corrupts the frame).
- grant_id  output  GW  index of the current or most recent grant.
- busy  output  1  high in any state other than IDLE.
- abort_count  output  16  number of watchdog aborts; saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; last_grant = N_SRC-1, so port 0 has first priority.
  - grant_id = 0, abort_count = 0, stall counter = 0.
  - All m_axis outputs = 0; all s_axis_tready = 0; busy = 0.
- Reset mid-frame discards the frame in flight. No tlast is emitted. Sources must restart their frames.
- IDLE:
  - m_axis_tvalid = 0 and all s_axis_tready = 0.
  - If any s_axis_tvalid is high, register the winner: the first valid index scanning last_grant+1, +2, … modulo N_SRC.
  - Update grant_id to the winner and go to XFER next cycle.
  - Arbitration latency is 1 cycle: a request seen in cycle t gives its first m_axis beat in cycle t+1 at the earliest.
- XFER (g = grant):
  - Combinational pass-through, zero added latency:
    - m_axis_tdata/tvalid/tlast/tuser = s_axis_*[g].
    - s_axis_tready[g] = m_axis_tready; all other tready = 0.
  - On a handshake with tlast: last_grant <= g and go to IDLE. There is no back-to-back grant in the same cycle; at least one IDLE cycle separates frames.
  - Stall counter:
    - Clears on entering XFER and on any cycle where s_axis_tvalid[g] = 1.
    - Increments otherwise.
    - If STALL_TIMEOUT > 0, the counter equals STALL_TIMEOUT-1 and s_axis_tvalid[g] = 0 in that cycle, go to ABORT.
    - If the source asserts valid in that same cycle, the beat wins and no abort occurs.
  - m_axis_tready low does not advance the stall counter when the source is valid. Backpressure is never a stall.
- ABORT:
  - Drive m_axis_tvalid = 1, tdata = 8'h00, tlast = 1, tuser = 1; all s_axis_tready = 0.
  - Hold these values until m_axis_tready. Then abort_count += 1 (saturating) and go to FLUSH.
- FLUSH:
  - m_axis_tvalid = 0; s_axis_tready[g] = 1; discard beats.
  - On a source beat with tlast: last_grant <= g and go to IDLE.
  - The watchdog is inactive in FLUSH. A source that never sends tlast holds the arbiter, which is by design.
- grant_id holds its value through IDLE until the next grant.
- The m_axis outputs obey AXI-Stream: once tvalid is asserted, data and last are stable until handshake. This holds because the source also obeys AXIS, and because ABORT is entered only when the source is not valid.

Test Plan:
- Single source: port 1 sends a 5-byte frame 11..15 with m_tready = 1 → m_axis shows 11..15 on 5 consecutive cycles starting 1 cycle after the first tvalid; tlast on 15; grant_id = 1; abort_count = 0.
- Round-robin: all 3 ports continuously offer 4-byte frames → grant order 0,1,2,0,1,2; one IDLE cycle between frames; no interleaved bytes.
- Backpressure: m_tready toggles 1,0 every cycle during a 64-byte frame → all 64 bytes delivered in order; no abort even though the frame exceeds 64 cycles.
- Watchdog: STALL_TIMEOUT = 8; port 2 sends 3 bytes and then drops tvalid → after 8 idle cycles, m_axis emits 00 with tlast = 1 and tuser = 1; abort_count = 1; the remaining port 2 bytes up to its tlast are accepted with no m_axis output.
- Boundary: the source reasserts tvalid exactly in the 8th stall cycle → no abort; the frame completes normally.
- Async reset mid-frame with port 0 granted → outputs 0 immediately; after release, port 0 wins the first request over simultaneous requests from ports 1 and 2.
